// File: rtl/mem_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl_pkg
// Description : Memory map constants, controller state encoding and the
//               byte-lane helper shared by the bus controller files.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_ctrl_pkg;

    // Region map: peripherals, RAM, FRAM and interrupt vector table
    localparam logic [15:0] c_periph_base = 16'h0000;
    localparam logic [15:0] c_periph_len  = 16'h1000;
    localparam logic [15:0] c_ram_base    = 16'h1C00;
    localparam logic [15:0] c_ram_len     = 16'h0800;
    localparam logic [15:0] c_fram_base   = 16'h4400;
    localparam logic [15:0] c_fram_len    = 16'hBB80;
    localparam logic [15:0] c_ivt_base    = 16'hFF80;
    localparam logic [15:0] c_ivt_len     = 16'h0080;

    // Default wait states; FRAM is the only slow device
    localparam logic [3:0]  c_periph_ws   = 4'd0;
    localparam logic [3:0]  c_ram_ws      = 4'd0;
    localparam logic [3:0]  c_fram_ws     = 4'd1;
    localparam logic [3:0]  c_ivt_ws      = 4'd0;

    // RAM and IVT are write-protected from the CPU bus by default
    localparam logic [3:0]  c_wp_default  = 4'b1010;

    // Value returned on a failed read
    localparam logic [15:0] c_vacant      = 16'h3FFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Byte accesses use the lane picked by the address LSB; words use both
    function automatic logic [1:0] lane_enable(input logic bw, input logic a0);
        if (!bw) return 2'b11;
        return a0 ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_ctrl_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl_addr_decoder
// Description : Combinational region decoder. Returns hit flag, one-hot
//               region select and offset into the region; the lowest region
//               index wins when regions overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl_addr_decoder #(
    parameter int                 NREG        = 4,
    parameter logic [NREG*16-1:0] REGION_BASE = '0,
    parameter logic [NREG*16-1:0] REGION_LEN  = '0
) (
    input  logic [15:0]     i_addr,
    output logic            o_hit,
    output logic [NREG-1:0] o_sel,
    output logic [15:0]     o_offset
);

    logic [NREG-1:0] w_match;

    // Range compare per region; 17 bits so base+len may reach 0x10000
    for (genvar gi = 0; gi < NREG; gi++) begin : g_region
        logic [16:0] w_a;
        logic [16:0] w_lo;
        logic [16:0] w_hi;
        assign w_a          = {1'b0, i_addr};
        assign w_lo         = {1'b0, REGION_BASE[gi*16 +: 16]};
        assign w_hi         = w_lo + {1'b0, REGION_LEN[gi*16 +: 16]};
        assign w_match[gi]  = (w_a >= w_lo) && (w_a < w_hi);
    end

    // Priority pick: scan downward so the lowest matching index is kept
    always_comb begin
        o_hit    = 1'b0;
        o_sel    = '0;
        o_offset = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit    = 1'b1;
                o_sel    = '0;
                o_sel[i] = 1'b1;
                o_offset = i_addr - REGION_BASE[i*16 +: 16];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : CPU-bus to region bridge with registered read mux, per-region
//               wait states, write protection, byte lanes, ready handshake and
//               bus-error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int                 NREG        = 4,
    parameter logic [NREG*16-1:0] REGION_BASE = {c_ivt_base, c_fram_base, c_ram_base, c_periph_base},
    parameter logic [NREG*16-1:0] REGION_LEN  = {c_ivt_len,  c_fram_len,  c_ram_len,  c_periph_len},
    parameter logic [NREG*4-1:0]  REGION_WS   = {c_ivt_ws,   c_fram_ws,   c_ram_ws,   c_periph_ws},
    parameter logic [NREG-1:0]    REGION_WP   = c_wp_default,
    parameter logic [15:0]        VACANT      = c_vacant
) (
    input  logic               MCLK,
    input  logic               rst,
    input  logic               MREQ,
    input  logic [15:0]        MAB,
    input  logic [15:0]        MDBwrite,
    input  logic               MW,
    input  logic               BW,
    output logic [15:0]        MDBread,
    output logic               MRDY,
    output logic               BUSERR,
    output logic [NREG-1:0]    reg_sel,
    output logic [15:0]        reg_addr,
    output logic [15:0]        reg_wdata,
    output logic               reg_we,
    output logic [1:0]         reg_be,
    input  logic [NREG*16-1:0] reg_rdata
);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_mw;
    logic              r_bw;
    logic [NREG-1:0]   r_hit_sel;
    logic [15:0]       r_mdbread;
    logic              r_mrdy;
    logic              r_buserr;
    logic [NREG-1:0]   r_reg_sel;
    logic [15:0]       r_reg_addr;
    logic [15:0]       r_reg_wdata;
    logic              r_reg_we;
    logic [1:0]        r_reg_be;

    logic [15:0]       w_eff_addr;
    logic              w_dec_hit;
    logic [NREG-1:0]   w_dec_sel;
    logic [15:0]       w_dec_off;
    logic [3:0]        w_ws;
    logic              w_wp;
    logic [15:0]       w_rd_word;
    logic [15:0]       w_rd_fmt;

    // Word accesses are aligned down before decoding
    assign w_eff_addr = BW ? MAB : {MAB[15:1], 1'b0};

    mem_bus_ctrl_addr_decoder #(
        .NREG        (NREG),
        .REGION_BASE (REGION_BASE),
        .REGION_LEN  (REGION_LEN)
    ) u_dec (
        .i_addr   (w_eff_addr),
        .o_hit    (w_dec_hit),
        .o_sel    (w_dec_sel),
        .o_offset (w_dec_off)
    );

    // Per-region attribute lookup for the request and read-data mux for ACCESS
    always_comb begin
        w_ws      = '0;
        w_wp      = 1'b0;
        w_rd_word = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_dec_sel[i]) begin
                w_ws = REGION_WS[i*4 +: 4];
                w_wp = REGION_WP[i];
            end
            if (r_reg_sel[i]) begin
                w_rd_word = reg_rdata[i*16 +: 16];
            end
        end
    end

    // Byte reads return the addressed lane zero-extended
    assign w_rd_fmt = r_bw ? {8'h00, (r_reg_be[1] ? w_rd_word[15:8] : w_rd_word[7:0])}
                           : w_rd_word;

    // Access sequencer; all bus and region outputs are registered here
    always_ff @(posedge MCLK) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mw        <= 1'b0;
            r_bw        <= 1'b0;
            r_hit_sel   <= '0;
            r_mdbread   <= '0;
            r_mrdy      <= 1'b0;
            r_buserr    <= 1'b0;
            r_reg_sel   <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_be    <= '0;
        end else begin
            r_mrdy   <= 1'b0;
            r_buserr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (MREQ) begin
                        r_mw        <= MW;
                        r_bw        <= BW;
                        r_hit_sel   <= w_dec_sel;
                        r_reg_addr  <= w_dec_off;
                        r_reg_wdata <= BW ? {MDBwrite[7:0], MDBwrite[7:0]} : MDBwrite;
                        r_reg_be    <= lane_enable(BW, MAB[0]);
                        if (!w_dec_hit || (MW && w_wp)) begin
                            r_state  <= ST_ERR;
                            r_mrdy   <= 1'b1;
                            r_buserr <= 1'b1;
                            if (!MW) begin
                                r_mdbread <= VACANT;
                            end
                        end else if (w_ws != 4'd0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= w_ws - 4'd1;
                        end else begin
                            r_state   <= ST_ACCESS;
                            r_reg_sel <= w_dec_sel;
                            r_reg_we  <= MW;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state   <= ST_ACCESS;
                        r_reg_sel <= r_hit_sel;
                        r_reg_we  <= r_mw;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!r_mw) begin
                        r_mdbread <= w_rd_fmt;
                    end
                    r_reg_sel <= '0;
                    r_reg_we  <= 1'b0;
                    r_mrdy    <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign MDBread   = r_mdbread;
    assign MRDY      = r_mrdy;
    assign BUSERR    = r_buserr;
    assign reg_sel   = r_reg_sel;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_be    = r_reg_be;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_ctrl
// Description : Directed vector bench for mem_bus_ctrl with hand-written
//               reset-abort and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int NREG = 4;

    logic          MCLK = 1'b0;
    logic          rst;
    logic          MREQ;
    logic [15:0]   MAB;
    logic [15:0]   MDBwrite;
    logic          MW;
    logic          BW;
    logic [15:0]   MDBread;
    logic          MRDY;
    logic          BUSERR;
    logic [3:0]    reg_sel;
    logic [15:0]   reg_addr;
    logic [15:0]   reg_wdata;
    logic          reg_we;
    logic [1:0]    reg_be;
    logic [63:0]   reg_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 MCLK = ~MCLK;

    mem_bus_ctrl dut (
        .MCLK      (MCLK),
        .rst       (rst),
        .MREQ      (MREQ),
        .MAB       (MAB),
        .MDBwrite  (MDBwrite),
        .MW        (MW),
        .BW        (BW),
        .MDBread   (MDBread),
        .MRDY      (MRDY),
        .BUSERR    (BUSERR),
        .reg_sel   (reg_sel),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata)
    );

    typedef struct {
        logic        mw;
        logic        bw;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          rgn;    // region whose reg_rdata carries rdata
        logic [15:0] rdata;
        logic        err;
        int          lat;    // cycles from request edge to MRDY
        logic [3:0]  sel;
        logic [15:0] off;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] mdb;    // MDBread after the access
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction; called and returns at a negative clock edge
    task automatic run_vec(input vec_t v, input int idx);
        int          k;
        bit          got;
        int          nsel;
        logic [3:0]  s_sel;
        logic [15:0] s_addr;
        logic [15:0] s_wd;
        logic [1:0]  s_be;
        logic        s_we;
        logic        s_err;
        k = 0; got = 0; nsel = 0;
        s_sel = '0; s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0; s_err = 1'b0;
        MREQ = 1'b1; MAB = v.addr; MDBwrite = v.wdata; MW = v.mw; BW = v.bw;
        for (int i = 0; i < NREG; i++)
            reg_rdata[i*16 +: 16] = (i == v.rgn) ? v.rdata : 16'hDEAD;
        while (!got && k < 12) begin
            @(negedge MCLK);
            k++;
            if (reg_sel != 4'b0) begin
                nsel++;
                s_sel = reg_sel; s_addr = reg_addr; s_wd = reg_wdata; s_be = reg_be; s_we = reg_we;
            end
            if (MRDY) begin
                got   = 1;
                s_err = BUSERR;
            end
        end
        MREQ = 1'b0;
        chk($sformatf("v%0d_latency", idx), got ? 32'(k) : 32'd99, 32'(v.lat));
        chk($sformatf("v%0d_buserr", idx), 32'(s_err), 32'(v.err));
        chk($sformatf("v%0d_mdbread", idx), 32'(MDBread), 32'(v.mdb));
        chk($sformatf("v%0d_sel_cycles", idx), 32'(nsel), v.err ? 32'd0 : 32'd1);
        if (!v.err) begin
            chk($sformatf("v%0d_reg_sel", idx), 32'(s_sel), 32'(v.sel));
            chk($sformatf("v%0d_reg_addr", idx), 32'(s_addr), 32'(v.off));
            chk($sformatf("v%0d_reg_be", idx), 32'(s_be), 32'(v.be));
            chk($sformatf("v%0d_reg_we", idx), 32'(s_we), 32'(v.mw));
            chk($sformatf("v%0d_reg_wdata", idx), 32'(s_wd), 32'(v.wd));
        end
        @(negedge MCLK);
        chk($sformatf("v%0d_mrdy_pulse", idx), 32'(MRDY), 32'd0);
        chk($sformatf("v%0d_buserr_pulse", idx), 32'(BUSERR), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first;
        int mrdy_seen;

        //          mw    bw    addr      wdata     rgn rdata     err  lat sel      off       be     wd        mdb
        vecs[0]  = '{1'b0, 1'b0, 16'h1C02, 16'h5678, 1, 16'hBEEF, 1'b0, 2, 4'b0010, 16'h0002, 2'b11, 16'h5678, 16'hBEEF};
        vecs[1]  = '{1'b1, 1'b0, 16'h4400, 16'h1234, 2, 16'h0000, 1'b0, 3, 4'b0100, 16'h0000, 2'b11, 16'h1234, 16'hBEEF};
        vecs[2]  = '{1'b0, 1'b1, 16'h1C05, 16'h0000, 1, 16'hA55A, 1'b0, 2, 4'b0010, 16'h0005, 2'b10, 16'h0000, 16'h00A5};
        vecs[3]  = '{1'b1, 1'b0, 16'hFF80, 16'hCAFE, 3, 16'h0000, 1'b1, 1, 4'b0000, 16'h0000, 2'b00, 16'h0000, 16'h00A5};
        vecs[4]  = '{1'b0, 1'b0, 16'h1000, 16'h0000, 0, 16'h1111, 1'b1, 1, 4'b0000, 16'h0000, 2'b00, 16'h0000, 16'h3FFF};
        vecs[5]  = '{1'b1, 1'b1, 16'h0003, 16'h77AB, 0, 16'h0000, 1'b0, 2, 4'b0001, 16'h0003, 2'b10, 16'hABAB, 16'h3FFF};
        vecs[6]  = '{1'b0, 1'b0, 16'h0FFF, 16'h0000, 0, 16'h1357, 1'b0, 2, 4'b0001, 16'h0FFE, 2'b11, 16'h0000, 16'h1357};
        vecs[7]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 3, 16'h9AC3, 1'b0, 2, 4'b1000, 16'h007F, 2'b10, 16'h0000, 16'h009A};
        vecs[8]  = '{1'b1, 1'b0, 16'h1C10, 16'h4321, 1, 16'h0000, 1'b1, 1, 4'b0000, 16'h0000, 2'b00, 16'h0000, 16'h009A};
        vecs[9]  = '{1'b0, 1'b0, 16'h2400, 16'h0000, 1, 16'h0000, 1'b1, 1, 4'b0000, 16'h0000, 2'b00, 16'h0000, 16'h3FFF};
        vecs[10] = '{1'b0, 1'b1, 16'h4401, 16'h00FF, 2, 16'h1234, 1'b0, 3, 4'b0100, 16'h0001, 2'b10, 16'hFFFF, 16'h0012};

        rst = 1'b0; MREQ = 1'b0; MAB = '0; MDBwrite = '0; MW = 1'b0; BW = 1'b0; reg_rdata = '0;
        repeat (3) @(negedge MCLK);
        chk("reset_mdbread", 32'(MDBread), 32'd0);
        chk("reset_mrdy_buserr", 32'({MRDY, BUSERR}), 32'd0);
        chk("reset_region_strobes", 32'({reg_sel, reg_we, reg_be}), 32'd0);
        chk("reset_reg_addr", 32'(reg_addr), 32'd0);
        chk("reset_reg_wdata", 32'(reg_wdata), 32'd0);
        rst = 1'b1;
        @(negedge MCLK);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset asserted while a ws=1 FRAM read sits in WAIT
        MREQ = 1'b1; MAB = 16'h4402; MDBwrite = 16'h0000; MW = 1'b0; BW = 1'b0;
        reg_rdata = {16'hDEAD, 16'hAAAA, 16'hDEAD, 16'hDEAD};
        @(negedge MCLK);
        chk("abort_wait_no_sel", 32'(reg_sel), 32'd0);
        chk("abort_wait_addr_latched", 32'(reg_addr), 32'h0002);
        rst = 1'b0; MREQ = 1'b0;
        @(negedge MCLK);
        chk("abort_reg_addr", 32'(reg_addr), 32'd0);
        chk("abort_mdbread", 32'(MDBread), 32'd0);
        chk("abort_strobes", 32'({MRDY, BUSERR, reg_sel, reg_we, reg_be}), 32'd0);
        rst = 1'b1;
        mrdy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge MCLK);
            if (MRDY) mrdy_seen++;
        end
        chk("abort_no_mrdy", 32'(mrdy_seen), 32'd0);
        run_vec(vecs[0], 100);

        // Request held continuously: one access per ws+3 cycles, RESP ignores MREQ
        MREQ = 1'b1; MAB = 16'h1C02; MDBwrite = 16'h0000; MW = 1'b0; BW = 1'b0;
        reg_rdata = {16'hDEAD, 16'hDEAD, 16'hBEEF, 16'hDEAD};
        pulses = 0; first = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge MCLK);
            if (MRDY) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        MREQ = 1'b0;
        chk("b2b_mrdy_count", 32'(pulses), 32'd3);
        chk("b2b_first_mrdy", 32'(first), 32'd2);
        chk("b2b_mdbread", 32'(MDBread), 32'hBEEF);
        repeat (3) @(negedge MCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
